// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_pkg : shared 7-segment types and the hex/segment pattern table        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PUBLISH = 1'b1
  } state_t;

  // Index is the nibble value; segment order is {A,B,C,D,E,F,G}, A in the MSB.
  localparam seg_t c_seg_table [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage
`default_nettype wire

// File: rtl/seg7_scan_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_capture_if : display bus in, captured frame out                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface seg7_scan_capture_if;
  import seg7_pkg::*;

  seg_t                  seg_i;
  logic [NUM_DIGITS-1:0] an_i;
  logic [15:0]           value_o;
  logic [NUM_DIGITS-1:0] digit_err_o;
  logic                  valid_o;

  modport master (
    output seg_i, an_i,
    input  value_o, digit_err_o, valid_o
  );

  modport slave (
    input  seg_i, an_i,
    output value_o, digit_err_o, valid_o
  );
endinterface
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_to_hex : combinational segment-pattern to nibble decoder              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_to_hex
  import seg7_pkg::*;
(
  input  seg_t       i_seg,
  output logic [3:0] o_nibble,
  output logic       o_invalid
);

  always_comb begin
    o_nibble  = 4'h0;
    o_invalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == c_seg_table[i]) begin
        o_nibble  = 4'(i);
        o_invalid = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_scan_capture : recovers a 4-digit hex word from a multiplexed         |
// | 7-segment bus once every digit has been seen stable                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_capture_if.slave bus
);

  localparam logic [7:0] c_stable    = 8'(STABLE_CYCLES);
  localparam logic [7:0] c_count_max = 8'hFF;

  state_t                r_state;
  state_t                w_state_next;
  logic [10:0]           r_prev_pair;
  logic [7:0]            r_count;
  logic [7:0]            w_count_next;
  logic [NUM_DIGITS-1:0] r_seen;
  logic [NUM_DIGITS-1:0] w_seen_next;
  logic [NUM_DIGITS-1:0] w_seen_capt;
  logic [15:0]           r_pend_value;
  logic [NUM_DIGITS-1:0] r_pend_err;
  logic [15:0]           r_value;
  logic [NUM_DIGITS-1:0] r_digit_err;
  logic                  r_valid;

  logic [10:0]           w_pair;
  logic                  w_legal;
  logic                  w_same;
  logic                  w_capture;
  logic                  w_publish;
  logic [1:0]            w_digit;
  logic [3:0]            w_nibble;
  logic                  w_invalid;

  seg7_to_hex u_decode (
    .i_seg     (bus.seg_i),
    .o_nibble  (w_nibble),
    .o_invalid (w_invalid)
  );

  assign w_pair  = {bus.seg_i, bus.an_i};
  assign w_legal = $onehot(bus.an_i);
  assign w_same  = (w_pair == r_prev_pair);

  always_comb begin
    w_count_next = 8'd0;
    if (w_legal) begin
      if (!w_same)
        w_count_next = 8'd1;
      else if (r_count == c_count_max)
        w_count_next = r_count;
      else
        w_count_next = r_count + 8'd1;
    end
  end

  // A saturated run sitting at the threshold must not re-capture.
  assign w_capture   = w_legal && (w_count_next == c_stable) && !(w_same && (r_count == c_stable));
  assign w_seen_capt = w_capture ? bus.an_i : '0;

  always_comb begin
    w_digit = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.an_i[i])
        w_digit = 2'(i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_publish    = 1'b0;
    w_seen_next  = r_seen | w_seen_capt;
    case (r_state)
      ST_COLLECT: begin
        if ((r_seen | w_seen_capt) == '1)
          w_state_next = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        // A capture on this edge belongs to the next frame.
        w_publish    = 1'b1;
        w_seen_next  = w_seen_capt;
        w_state_next = ST_COLLECT;
      end
      default: w_state_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_COLLECT;
      r_prev_pair  <= '0;
      r_count      <= '0;
      r_seen       <= '0;
      r_pend_value <= '0;
      r_pend_err   <= '0;
      r_value      <= '0;
      r_digit_err  <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_prev_pair <= w_pair;
      r_count     <= w_count_next;
      r_seen      <= w_seen_next;
      r_valid     <= w_publish;
      if (w_capture) begin
        r_pend_value[{w_digit, 2'b00} +: 4] <= w_nibble;
        r_pend_err[w_digit]                 <= w_invalid;
      end
      if (w_publish) begin
        r_value     <= r_pend_value;
        r_digit_err <= r_pend_err;
      end
    end
  end

  assign bus.value_o     = r_value;
  assign bus.digit_err_o = r_digit_err;
  assign bus.valid_o     = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_seg7_scan_capture : directed + random bench with a behavioural model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_capture;

  localparam int STABLE = 4;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  seg7_scan_capture_if bus ();

  seg7_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: length of the current run of identical legal samples.
  int          run;
  int          prev;
  logic [15:0] m_pend;
  logic [3:0]  m_perr;
  int          m_seen;
  bit          m_due;
  bit          started = 0;
  logic [15:0] exp_value;
  logic [3:0]  exp_err;
  logic        exp_valid;
  bit          m_legal;
  bit          m_bad;
  int          m_nib;
  int          m_dig;

  always @(posedge clk) begin
    if (rst) begin
      started   = 1;
      run       = 0;
      prev      = -1;
      m_pend    = '0;
      m_perr    = '0;
      m_seen    = 0;
      m_due     = 0;
      exp_value = '0;
      exp_err   = '0;
      exp_valid = 1'b0;
    end else begin
      m_legal = ($countones(bus.an_i) == 1);
      if (!m_legal)
        run = 0;
      else if (int'({bus.seg_i, bus.an_i}) == prev)
        run++;
      else
        run = 1;
      prev      = int'({bus.seg_i, bus.an_i});
      exp_valid = 1'b0;
      if (m_due) begin
        exp_value = m_pend;
        exp_err   = m_perr;
        exp_valid = 1'b1;
        m_seen    = 0;
        m_due     = 0;
      end
      if (m_legal && run == STABLE) begin
        m_nib = 0;
        m_bad = 1;
        m_dig = 0;
        for (int i = 0; i < 16; i++)
          if (bus.seg_i == SEG_TABLE[i]) begin
            m_nib = i;
            m_bad = 0;
          end
        for (int d = 0; d < 4; d++)
          if (bus.an_i[d]) m_dig = d;
        m_pend[m_dig*4 +: 4] = m_nib[3:0];
        m_perr[m_dig]        = m_bad;
        m_seen               = m_seen | (1 << m_dig);
      end
      if (m_seen == 15) m_due = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("value_o",     32'(bus.value_o),     32'(exp_value));
      check("digit_err_o", 32'(bus.digit_err_o), 32'(exp_err));
      check("valid_o",     32'(bus.valid_o),     32'(exp_valid));
      if (bus.valid_o === 1'b1) pulses++;
    end
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    bus.an_i  = a;
    bus.seg_i = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b0001, s0, 6);
    hold(4'b0010, s1, 6);
    hold(4'b0100, s2, 6);
    hold(4'b1000, s3, 6);
    hold(4'b0000, 7'h00, 4);
  endtask

  int          p0;
  logic [3:0]  ra;
  logic [6:0]  rs;

  initial begin
    bus.an_i  = '0;
    bus.seg_i = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_value", 32'(bus.value_o), 32'h0);
    check("reset_err",   32'(bus.digit_err_o), 32'h0);
    check("reset_valid", 32'(bus.valid_o), 32'h0);

    // Clean frame
    p0 = pulses;
    frame(7'h5B, 7'h4E, 7'h7F, 7'h30);
    check("clean_value",  32'(bus.value_o), 32'h18C5);
    check("clean_err",    32'(bus.digit_err_o), 32'h0);
    check("clean_pulses", 32'(pulses - p0), 32'd1);

    // Short glitch between digits
    p0 = pulses;
    hold(4'b0001, 7'h5B, 6);
    hold(4'b0010, 7'h4E, 6);
    hold(4'b0100, 7'h00, 3);
    hold(4'b0100, 7'h7F, 6);
    hold(4'b1000, 7'h30, 6);
    hold(4'b0000, 7'h00, 4);
    check("glitch_value",  32'(bus.value_o), 32'h18C5);
    check("glitch_err",    32'(bus.digit_err_o), 32'h0);
    check("glitch_pulses", 32'(pulses - p0), 32'd1);

    // Unrecognised pattern on digit 2
    frame(7'h5B, 7'h4E, 7'h01, 7'h30);
    check("invalid_value", 32'(bus.value_o), 32'h10C5);
    check("invalid_err",   32'(bus.digit_err_o), 32'h4);

    // Illegal select mid-frame
    p0 = pulses;
    hold(4'b0001, 7'h7E, 6);
    hold(4'b0010, 7'h30, 6);
    hold(4'b0011, 7'h7E, 20);
    hold(4'b0000, 7'h7E, 20);
    check("illegal_an_pulses", 32'(pulses - p0), 32'd0);
    hold(4'b0100, 7'h6D, 6);
    hold(4'b1000, 7'h79, 6);
    hold(4'b0000, 7'h00, 4);
    check("illegal_an_value",  32'(bus.value_o), 32'h3210);
    check("illegal_an_pulses2", 32'(pulses - p0), 32'd1);

    // Overwrite digit 0 before the frame completes
    p0 = pulses;
    hold(4'b0001, 7'h79, 6);
    frame(7'h7B, 7'h30, 7'h30, 7'h30);
    check("overwrite_value",  32'(bus.value_o), 32'h1119);
    check("overwrite_pulses", 32'(pulses - p0), 32'd1);

    // Mid-frame reset discards the partial frame
    hold(4'b0001, 7'h47, 6);
    hold(4'b0010, 7'h47, 6);
    hold(4'b0100, 7'h47, 6);
    @(negedge clk);
    rst      = 1'b1;
    bus.an_i = '0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_value", 32'(bus.value_o), 32'h0);
    check("midrst_err",   32'(bus.digit_err_o), 32'h0);
    check("midrst_valid", 32'(bus.valid_o), 32'h0);
    p0 = pulses;
    hold(4'b1000, 7'h47, 6);
    hold(4'b0100, 7'h47, 6);
    hold(4'b0010, 7'h47, 6);
    check("midrst_nopulse", 32'(pulses - p0), 32'd0);
    hold(4'b0001, 7'h47, 6);
    hold(4'b0000, 7'h00, 4);
    check("midrst_final", 32'(bus.value_o), 32'hFFFF);
    check("midrst_pulses", 32'(pulses - p0), 32'd1);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 19))
        0:       ra = 4'b0000;
        1:       ra = 4'($urandom);
        default: ra = 4'(1 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 7) == 0)
        rs = 7'($urandom);
      else
        rs = SEG_TABLE[$urandom_range(0, 15)];
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      hold(ra, rs, $urandom_range(1, 7));
    end
    hold(4'b0000, 7'h00, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
